mem_stage: RTL and testbench

//  MEM stage of the 16-bit pipeline, directly downstream of EX. Holds the EX/MEM

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 16-bit pipeline, directly downstream of EX.
// Holds the EX/MEM register, a data memory with MEM_LATENCY wait states per
// load/store, branch resolution and the MEM/WB register. While a memory access
// is still waiting, mem_busy stalls the upstream stages and MEM/WB receives
// bubbles.
//
// Ports:
//   clock, reset_n              rising-edge clock, synchronous active-low reset
//   adderOutput, outputALU,     EX results: branch target, ALU result/address,
//   zeroEx, data2ALU_out, RD    zero flag, store data, destination register
//   memReadEx, memWriteEx,      EX control fields
//   branchEx, regWriteEx,
//   memToRegEx
//   flush                       replace the incoming EX instruction with a bubble
//   mem_busy                    stall request to IF/ID/EX
//   PCSrc, branchTarget         taken-branch redirect
//   result_ALU_MEM, rd_mem,     EX/MEM fields fed back to EX for forwarding
//   regWrite_mem
//   readData_WB, aluResult_WB,  MEM/WB register
//   rd_WB, regWrite_WB,
//   memToReg_WB
module mem_stage #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] adderOutput,
    input  logic [15:0] outputALU,
    input  logic        zeroEx,
    input  logic [15:0] data2ALU_out,
    input  logic [2:0]  RD,
    input  logic        memReadEx,
    input  logic        memWriteEx,
    input  logic        branchEx,
    input  logic        regWriteEx,
    input  logic        memToRegEx,
    input  logic        flush,
    output logic        mem_busy,
    output logic        PCSrc,
    output logic [15:0] branchTarget,
    output logic [15:0] result_ALU_MEM,
    output logic [2:0]  rd_mem,
    output logic        regWrite_mem,
    output logic [15:0] readData_WB,
    output logic [15:0] aluResult_WB,
    output logic [2:0]  rd_WB,
    output logic        regWrite_WB,
    output logic        memToReg_WB
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam logic [3:0]  LatCnt = 4'(MEM_LATENCY);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t      state;
    logic [3:0]  cnt;

    // EX/MEM fields not exposed as outputs
    logic        zeroMem;
    logic [15:0] storeData;
    logic        memRead_mem;
    logic        memWrite_mem;
    logic        branch_mem;
    logic        memToReg_mem;

    logic [15:0] mem [DEPTH];

    logic             memOp;
    logic             memDone;
    logic [AddrW-1:0] addr;
    logic [15:0]      loadData;

    assign memOp    = memRead_mem | memWrite_mem;
    assign mem_busy = memOp & (cnt != LatCnt);
    assign memDone  = memOp & ~mem_busy;
    assign addr     = result_ALU_MEM[AddrW-1:0];
    // Simultaneous read+write is treated as a store; the load result reads as 0.
    assign loadData = (memRead_mem && !memWrite_mem) ? mem[addr] : 16'h0000;
    assign PCSrc    = branch_mem & zeroMem;

    // Memory array is not reset; a reset on the completion edge suppresses the write.
    always_ff @(posedge clock) begin
        if (reset_n && memDone && memWrite_mem) begin
            mem[addr] <= storeData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= StIdle;
            cnt            <= 4'd0;
            branchTarget   <= 16'h0000;
            result_ALU_MEM <= 16'h0000;
            zeroMem        <= 1'b0;
            storeData      <= 16'h0000;
            rd_mem         <= 3'd0;
            memRead_mem    <= 1'b0;
            memWrite_mem   <= 1'b0;
            branch_mem     <= 1'b0;
            regWrite_mem   <= 1'b0;
            memToReg_mem   <= 1'b0;
            readData_WB    <= 16'h0000;
            aluResult_WB   <= 16'h0000;
            rd_WB          <= 3'd0;
            regWrite_WB    <= 1'b0;
            memToReg_WB    <= 1'b0;
        end else begin
            // Wait-state counter: counts edges spent busy, clears on completion.
            unique case (state)
                StIdle: begin
                    if (mem_busy) begin
                        cnt   <= 4'd1;
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (mem_busy) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt   <= 4'd0;
                        state <= StIdle;
                    end
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= StIdle;
                end
            endcase

            if (!mem_busy) begin
                // EX/MEM capture; flush zeroes only the control fields.
                branchTarget   <= adderOutput;
                result_ALU_MEM <= outputALU;
                zeroMem        <= zeroEx;
                storeData      <= data2ALU_out;
                rd_mem         <= RD;
                memRead_mem    <= memReadEx & ~flush;
                memWrite_mem   <= memWriteEx & ~flush;
                branch_mem     <= branchEx & ~flush;
                regWrite_mem   <= regWriteEx & ~flush;
                memToReg_mem   <= memToRegEx & ~flush;

                readData_WB  <= loadData;
                aluResult_WB <= result_ALU_MEM;
                rd_WB        <= rd_mem;
                regWrite_WB  <= regWrite_mem;
                memToReg_WB  <= memToReg_mem;
            end else begin
                // EX/MEM holds; WB receives a bubble each waiting cycle.
                readData_WB  <= 16'h0000;
                aluResult_WB <= 16'h0000;
                rd_WB        <= 3'd0;
                regWrite_WB  <= 1'b0;
                memToReg_WB  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: two instances share the EX-side inputs, one
// with no wait states (d0) and one with three wait states (d3).
module tb_mem_stage;

    logic        clock;
    logic        reset_n;
    logic [15:0] adderOutput;
    logic [15:0] outputALU;
    logic        zeroEx;
    logic [15:0] data2ALU_out;
    logic [2:0]  RD;
    logic        memReadEx;
    logic        memWriteEx;
    logic        branchEx;
    logic        regWriteEx;
    logic        memToRegEx;
    logic        flush;

    logic        busy0, pcSrc0, regWriteMem0, regWriteWb0, memToRegWb0;
    logic [15:0] target0, aluMem0, readWb0, aluWb0;
    logic [2:0]  rdMem0, rdWb0;

    logic        busy3, pcSrc3, regWriteMem3, regWriteWb3, memToRegWb3;
    logic [15:0] target3, aluMem3, readWb3, aluWb3;
    logic [2:0]  rdMem3, rdWb3;

    int checks = 0;
    int failures = 0;

    mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) d0 (
        .clock(clock), .reset_n(reset_n), .adderOutput(adderOutput), .outputALU(outputALU),
        .zeroEx(zeroEx), .data2ALU_out(data2ALU_out), .RD(RD), .memReadEx(memReadEx),
        .memWriteEx(memWriteEx), .branchEx(branchEx), .regWriteEx(regWriteEx),
        .memToRegEx(memToRegEx), .flush(flush), .mem_busy(busy0), .PCSrc(pcSrc0),
        .branchTarget(target0), .result_ALU_MEM(aluMem0), .rd_mem(rdMem0),
        .regWrite_mem(regWriteMem0), .readData_WB(readWb0), .aluResult_WB(aluWb0),
        .rd_WB(rdWb0), .regWrite_WB(regWriteWb0), .memToReg_WB(memToRegWb0)
    );

    mem_stage #(.DEPTH(256), .MEM_LATENCY(3)) d3 (
        .clock(clock), .reset_n(reset_n), .adderOutput(adderOutput), .outputALU(outputALU),
        .zeroEx(zeroEx), .data2ALU_out(data2ALU_out), .RD(RD), .memReadEx(memReadEx),
        .memWriteEx(memWriteEx), .branchEx(branchEx), .regWriteEx(regWriteEx),
        .memToRegEx(memToRegEx), .flush(flush), .mem_busy(busy3), .PCSrc(pcSrc3),
        .branchTarget(target3), .result_ALU_MEM(aluMem3), .rd_mem(rdMem3),
        .regWrite_mem(regWriteMem3), .readData_WB(readWb3), .aluResult_WB(aluWb3),
        .rd_WB(rdWb3), .regWrite_WB(regWriteWb3), .memToReg_WB(memToRegWb3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setNop();
        adderOutput = 16'h0; outputALU = 16'h0; zeroEx = 1'b0; data2ALU_out = 16'h0;
        RD = 3'd0; memReadEx = 1'b0; memWriteEx = 1'b0; branchEx = 1'b0;
        regWriteEx = 1'b0; memToRegEx = 1'b0; flush = 1'b0;
    endtask

    task automatic setStore(input logic [15:0] a, input logic [15:0] d);
        setNop();
        outputALU = a; data2ALU_out = d; memWriteEx = 1'b1;
    endtask

    task automatic setLoad(input logic [15:0] a, input logic [2:0] r);
        setNop();
        outputALU = a; RD = r; memReadEx = 1'b1; regWriteEx = 1'b1; memToRegEx = 1'b1;
    endtask

    task automatic doReset();
        setNop();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Ticks until d3 is no longer busy; returns busy samples seen. Expiry counts as a failure.
    task automatic waitIdle3(output int busyCycles);
        busyCycles = 0;
        while (busy3 && busyCycles < 20) begin
            busyCycles++;
            tick();
        end
        if (busy3) begin
            checks++;
            failures++;
            $display("FAIL wait_idle3: mem_busy still %0b after %0d cycles, required 0",
                     busy3, busyCycles);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({busy0, pcSrc0, target0, aluMem0, rdMem0, regWriteMem0, readWb0, aluWb0,
             rdWb0, regWriteWb0, memToRegWb0} !== '0) begin
            failures++;
            $display("FAIL reset_d0: outputs not all zero (busy=%0b wb=%h)", busy0, readWb0);
        end
        checks++;
        if ({busy3, pcSrc3, target3, aluMem3, rdMem3, regWriteMem3, readWb3, aluWb3,
             rdWb3, regWriteWb3, memToRegWb3} !== '0) begin
            failures++;
            $display("FAIL reset_d3: outputs not all zero (busy=%0b wb=%h)", busy3, readWb3);
        end
    endtask

    task automatic test_store_load_l0();
        logic sawBusy;
        doReset();
        sawBusy = busy0;
        setStore(16'h0005, 16'hBEEF);
        tick();
        sawBusy |= busy0;
        setLoad(16'h0005, 3'd3);
        tick();
        sawBusy |= busy0;
        setNop();
        tick();
        sawBusy |= busy0;
        checks++;
        if (readWb0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL l0_load_data: got %h, required BEEF", readWb0);
        end
        checks++;
        if ({memToRegWb0, regWriteWb0, rdWb0} !== {1'b1, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL l0_load_ctrl: got m2r=%0b rw=%0b rd=%0d, required 1 1 3",
                     memToRegWb0, regWriteWb0, rdWb0);
        end
        checks++;
        if (sawBusy !== 1'b0) begin
            failures++;
            $display("FAIL l0_never_busy: mem_busy seen %0b, required 0", sawBusy);
        end
    endtask

    task automatic test_wait_states();
        int n;
        int bubbles;
        doReset();
        setStore(16'h0007, 16'h1234);
        tick();
        waitIdle3(n);
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL l3_store_busy: busy %0d cycles, required 3", n);
        end
        setLoad(16'h0007, 3'd2);
        tick();
        // Load is now in EX/MEM; count busy cycles and WB bubbles.
        n = 0;
        bubbles = 0;
        while (busy3 && n < 20) begin
            n++;
            tick();
            if (busy3 && !regWriteWb3 && !memToRegWb3) bubbles++;
            if (!busy3 && !regWriteWb3 && !memToRegWb3) bubbles++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL l3_load_busy: busy %0d cycles, required 3", n);
        end
        checks++;
        if (bubbles !== 3) begin
            failures++;
            $display("FAIL l3_bubbles: got %0d bubbles, required 3", bubbles);
        end
        setNop();
        tick();
        checks++;
        if ({readWb3, regWriteWb3, memToRegWb3, rdWb3} !== {16'h1234, 1'b1, 1'b1, 3'd2}) begin
            failures++;
            $display("FAIL l3_load_data: got %h rw=%0b m2r=%0b rd=%0d, required 1234 1 1 2",
                     readWb3, regWriteWb3, memToRegWb3, rdWb3);
        end
    endtask

    task automatic test_branch();
        doReset();
        setNop();
        branchEx = 1'b1; zeroEx = 1'b1; adderOutput = 16'h0040;
        tick();
        checks++;
        if ({pcSrc0, target0} !== {1'b1, 16'h0040}) begin
            failures++;
            $display("FAIL branch_taken: got pcsrc=%0b target=%h, required 1 0040",
                     pcSrc0, target0);
        end
        setNop();
        tick();
        checks++;
        if (pcSrc0 !== 1'b0) begin
            failures++;
            $display("FAIL branch_one_cycle: got pcsrc=%0b, required 0", pcSrc0);
        end
        branchEx = 1'b1; zeroEx = 1'b0; adderOutput = 16'h0080;
        tick();
        checks++;
        if ({pcSrc0, target0} !== {1'b0, 16'h0080}) begin
            failures++;
            $display("FAIL branch_not_taken: got pcsrc=%0b target=%h, required 0 0080",
                     pcSrc0, target0);
        end
        // A flushed branch must not redirect.
        setNop();
        branchEx = 1'b1; zeroEx = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (pcSrc0 !== 1'b0) begin
            failures++;
            $display("FAIL branch_flushed: got pcsrc=%0b, required 0", pcSrc0);
        end
    endtask

    task automatic test_flush();
        int n;
        doReset();
        setNop();
        regWriteEx = 1'b1; RD = 3'd5; outputALU = 16'h0022; flush = 1'b1;
        tick();
        checks++;
        if (regWriteMem0 !== 1'b0) begin
            failures++;
            $display("FAIL flush_mem: got regWrite_mem=%0b, required 0", regWriteMem0);
        end
        setNop();
        regWriteEx = 1'b1; RD = 3'd6; outputALU = 16'h0033;
        tick();
        checks++;
        if ({regWriteWb0, regWriteMem0, rdMem0} !== {1'b0, 1'b1, 3'd6}) begin
            failures++;
            $display("FAIL flush_wb: got wb_rw=%0b mem_rw=%0b rd_mem=%0d, required 0 1 6",
                     regWriteWb0, regWriteMem0, rdMem0);
        end
        setNop();
        tick();
        checks++;
        if ({regWriteWb0, rdWb0, aluWb0} !== {1'b1, 3'd6, 16'h0033}) begin
            failures++;
            $display("FAIL unflushed_wb: got rw=%0b rd=%0d alu=%h, required 1 6 0033",
                     regWriteWb0, rdWb0, aluWb0);
        end
        // Flush while d3 is busy must be ignored.
        doReset();
        setLoad(16'h0007, 3'd4);
        tick();
        flush = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy3, regWriteMem3, rdMem3} !== {1'b1, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL flush_busy_hold: got busy=%0b rw=%0b rd=%0d, required 1 1 4",
                     busy3, regWriteMem3, rdMem3);
        end
        flush = 1'b0;
        waitIdle3(n);
        setNop();
        tick();
        checks++;
        if ({regWriteWb3, rdWb3, readWb3} !== {1'b1, 3'd4, 16'h1234}) begin
            failures++;
            $display("FAIL flush_busy_wb: got rw=%0b rd=%0d data=%h, required 1 4 1234",
                     regWriteWb3, rdWb3, readWb3);
        end
    endtask

    task automatic test_reset_mid_access();
        int n;
        doReset();
        setStore(16'h0009, 16'h1111);
        tick();
        waitIdle3(n);
        setStore(16'h0009, 16'hAAAA);
        tick();       // store 1111 completes, store AAAA enters EX/MEM
        tick();       // second wait cycle
        reset_n = 1'b0;
        setNop();
        tick();
        checks++;
        if ({busy3, pcSrc3, target3, aluMem3, rdMem3, regWriteMem3, readWb3, aluWb3,
             rdWb3, regWriteWb3, memToRegWb3} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%0b alu_mem=%h, required all 0",
                     busy3, aluMem3);
        end
        reset_n = 1'b1;
        setLoad(16'h0009, 3'd1);
        tick();
        setNop();
        waitIdle3(n);
        tick();
        checks++;
        if (readWb3 !== 16'h1111) begin
            failures++;
            $display("FAIL midreset_no_write: got mem[9]=%h, required 1111", readWb3);
        end
    endtask

    task automatic test_addr_wrap();
        doReset();
        setStore(16'h0103, 16'h5555);
        tick();
        setLoad(16'h0003, 3'd7);
        tick();
        setNop();
        tick();
        checks++;
        if (readWb0 !== 16'h5555) begin
            failures++;
            $display("FAIL addr_wrap: got %h, required 5555", readWb0);
        end
        // Read and write together: store wins, read data is zero.
        setStore(16'h0003, 16'h7777);
        memReadEx = 1'b1;
        tick();
        setLoad(16'h0003, 3'd7);
        tick();
        checks++;
        if (readWb0 !== 16'h0000) begin
            failures++;
            $display("FAIL rw_both_data: got %h, required 0000", readWb0);
        end
        setNop();
        tick();
        checks++;
        if (readWb0 !== 16'h7777) begin
            failures++;
            $display("FAIL rw_both_store: got %h, required 7777", readWb0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        setNop();
        test_reset();
        test_store_load_l0();
        test_wait_states();
        test_branch();
        test_flush();
        test_reset_mid_access();
        test_addr_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
